// File: rtl/dsp_acc_ctrl.sv
// Sequencing controller for the dsp_acc serial accumulator.
// Drives end_of_acc every acc_len samples and tags real dout_vld pulses.
module dsp_acc_ctrl #(
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 arm,
  input  logic                 sync_in,
  input  logic [LEN_WIDTH-1:0] acc_len,
  output logic                 end_of_acc,
  output logic                 acc_vld,
  output logic [CNT_WIDTH-1:0] acc_cnt,
  output logic                 armed,
  output logic                 running,
  output logic                 sync_err
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] samp_cnt;
  logic [LEN_WIDTH-1:0] len_eff;
  logic [1:0]           dly;
  logic                 start;
  logic                 tick;
  logic                 wrap;
  logic                 on_bound;

  assign len_eff  = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
  assign start    = (state_q == ARMED) & ce & sync_in & ~arm;
  assign tick     = (state_q == RUN) & ce & ~arm;
  assign wrap     = (samp_cnt == '0);
  assign on_bound = (samp_cnt == len_q - LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arm) state_d = ARMED;
      ARMED:   if (start) state_d = RUN;
      RUN:     if (arm) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  // Length is latched on the start sync so acc_len edits wait for re-arm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= LEN_WIDTH'(1);
      samp_cnt <= '0;
    end else if (start) begin
      len_q    <= len_eff;
      samp_cnt <= len_eff - LEN_WIDTH'(1);
    end else if (tick) begin
      samp_cnt <= wrap ? len_q - LEN_WIDTH'(1)
                       : samp_cnt - LEN_WIDTH'(1);
    end
  end

  // Two-stage real tag matches dsp_acc end_of_acc to dout_vld latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly      <= '0;
      acc_cnt  <= '0;
      sync_err <= 1'b0;
    end else if (arm) begin
      dly      <= '0;
      acc_cnt  <= '0;
      sync_err <= 1'b0;
    end else if (ce) begin
      dly <= {dly[0], tick & wrap};
      if (dly[0]) acc_cnt <= acc_cnt + CNT_WIDTH'(1);
      if ((state_q == RUN) & sync_in & ~on_bound) sync_err <= 1'b1;
    end
  end

  assign end_of_acc = (state_q != RUN) | wrap;
  assign acc_vld    = dly[1];
  assign armed      = (state_q == ARMED);
  assign running    = (state_q == RUN);

endmodule

// File: tb/tb_dsp_acc_ctrl.sv
// Directed bench for dsp_acc_ctrl with a small dsp_acc reference
// model so accumulation sums can be checked against hand values.
module tb_dsp_acc_ctrl;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        arm;
  logic        sync_in;
  logic [15:0] acc_len;
  logic        end_of_acc;
  logic        acc_vld;
  logic [31:0] acc_cnt;
  logic        armed;
  logic        running;
  logic        sync_err;

  logic [31:0] din;
  logic [31:0] m_acc, m_s1, m_s2;
  logic        m_v1, m_v2;

  int npass = 0;
  int ntot  = 0;

  dsp_acc_ctrl #(.LEN_WIDTH(16), .CNT_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .arm        (arm),
    .sync_in    (sync_in),
    .acc_len    (acc_len),
    .end_of_acc (end_of_acc),
    .acc_vld    (acc_vld),
    .acc_cnt    (acc_cnt),
    .armed      (armed),
    .running    (running),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dsp_acc behaviour: flush on end_of_acc, dout two ce samples later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc <= '0; m_s1 <= '0; m_s2 <= '0;
      m_v1  <= 1'b0; m_v2 <= 1'b0;
    end else if (ce) begin
      if (end_of_acc) begin
        m_s1 <= m_acc + din; m_acc <= '0; m_v1 <= 1'b1;
      end else begin
        m_acc <= m_acc + din; m_v1 <= 1'b0;
      end
      m_s2 <= m_s1;
      m_v2 <= m_v1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_sync();
    sync_in = 1'b1;
    din     = 32'd1;
    step();
    sync_in = 1'b0;
    din     = 32'd2;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b0; arm = 1'b0; sync_in = 1'b0;
    acc_len = 16'd4; din = '0;
    #12;
    ntot++; if (end_of_acc !== 1'b1) $display("FAIL rst_eoa got %b exp 1", end_of_acc); else npass++;
    ntot++; if (acc_vld !== 1'b0) $display("FAIL rst_vld got %b exp 0", acc_vld); else npass++;
    ntot++; if (acc_cnt !== 32'd0) $display("FAIL rst_cnt got %0d exp 0", acc_cnt); else npass++;
    ntot++; if ({armed, running, sync_err} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {armed, running, sync_err}); else npass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    acc_len = 16'd4; ce = 1'b1;
    do_arm();
    ntot++; if ({armed, running} !== 2'b10) $display("FAIL basic_armed got %b exp 10", {armed, running}); else npass++;
    do_sync();
    ntot++; if (running !== 1'b1) $display("FAIL basic_running got %b exp 1", running); else npass++;
    for (int k = 1; k <= 12; k++) begin
      ntot++; if (end_of_acc !== (k % 4 == 0)) $display("FAIL basic_eoa k=%0d got %b", k, end_of_acc); else npass++;
      ntot++; if (acc_vld !== (k >= 6 && (k - 6) % 4 == 0)) $display("FAIL basic_vld k=%0d got %b", k, acc_vld); else npass++;
      if (k == 6) begin
        ntot++; if (m_s2 !== 32'd14) $display("FAIL basic_sum1 got %0d exp 14", m_s2); else npass++;
        ntot++; if (acc_cnt !== 32'd1) $display("FAIL basic_cnt1 got %0d exp 1", acc_cnt); else npass++;
      end
      if (k == 10) begin
        ntot++; if (m_s2 !== 32'd30) $display("FAIL basic_sum2 got %0d exp 30", m_s2); else npass++;
        ntot++; if (acc_cnt !== 32'd2) $display("FAIL basic_cnt2 got %0d exp 2", acc_cnt); else npass++;
      end
      step();
      din = din + 1;
    end
  endtask

  task automatic test_ce_gating();
    int nv = 0;
    acc_len = 16'd3; ce = 1'b1;
    do_arm();
    do_sync();
    for (int k = 1; k <= 22; k++) begin
      ce = (k % 2 == 1);
      if (acc_vld && ce) begin
        nv++;
        ntot++; if (m_s2 !== 32'(9 * nv)) $display("FAIL ce_sum n=%0d got %0d exp %0d", nv, m_s2, 9 * nv); else npass++;
        ntot++; if (acc_cnt !== 32'(nv)) $display("FAIL ce_cnt n=%0d got %0d", nv, acc_cnt); else npass++;
      end
      step();
      if (ce) din = din + 1;
    end
    ntot++; if (nv !== 3) $display("FAIL ce_pulses got %0d exp 3", nv); else npass++;
    ce = 1'b1;
  endtask

  task automatic test_sync_err();
    acc_len = 16'd8; ce = 1'b1;
    do_arm();
    do_sync();
    for (int k = 1; k <= 12; k++) begin
      sync_in = (k == 1 || k == 3);
      if (k == 2) begin
        ntot++; if (sync_err !== 1'b0) $display("FAIL serr_legal got %b exp 0", sync_err); else npass++;
      end
      if (k == 4) begin
        ntot++; if (sync_err !== 1'b1) $display("FAIL serr_set got %b exp 1", sync_err); else npass++;
      end
      if (k == 7 || k == 8) begin
        ntot++; if (end_of_acc !== (k == 8)) $display("FAIL serr_period k=%0d got %b", k, end_of_acc); else npass++;
      end
      step();
      din = din + 1;
    end
    sync_in = 1'b0;
    ntot++; if (acc_cnt !== 32'd1) $display("FAIL serr_cnt got %0d exp 1", acc_cnt); else npass++;
    do_arm();
    ntot++; if (sync_err !== 1'b0) $display("FAIL serr_clr got %b exp 0", sync_err); else npass++;
    ntot++; if (acc_cnt !== 32'd0) $display("FAIL serr_cntclr got %0d exp 0", acc_cnt); else npass++;
  endtask

  task automatic test_rearm();
    logic seen = 1'b0;
    acc_len = 16'd5; ce = 1'b1;
    do_arm();
    do_sync();
    step(); din = din + 1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    ntot++; if ({armed, running, end_of_acc} !== 3'b101) $display("FAIL rearm_state got %b exp 101", {armed, running, end_of_acc}); else npass++;
    for (int k = 0; k < 8; k++) begin
      seen = seen | acc_vld;
      step();
    end
    ntot++; if (seen !== 1'b0) $display("FAIL rearm_partial_vld got %b exp 0", seen); else npass++;
    ntot++; if (acc_cnt !== 32'd0) $display("FAIL rearm_cnt got %0d exp 0", acc_cnt); else npass++;
    do_sync();
    for (int k = 1; k < 7; k++) begin
      step(); din = din + 1;
    end
    ntot++; if (acc_vld !== 1'b1) $display("FAIL rearm_vld got %b exp 1", acc_vld); else npass++;
    ntot++; if (m_s2 !== 32'd20) $display("FAIL rearm_sum got %0d exp 20", m_s2); else npass++;
    ntot++; if (acc_cnt !== 32'd1) $display("FAIL rearm_cnt2 got %0d exp 1", acc_cnt); else npass++;
  endtask

  task automatic test_len_edge();
    acc_len = 16'd0; ce = 1'b1;
    do_arm();
    do_sync();
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) acc_len = 16'd3;
      ntot++; if (end_of_acc !== 1'b1) $display("FAIL len0_eoa k=%0d got %b exp 1", k, end_of_acc); else npass++;
      if (k >= 3 && k <= 6) begin
        ntot++; if (acc_vld !== 1'b1) $display("FAIL len0_vld k=%0d got %b exp 1", k, acc_vld); else npass++;
        ntot++; if (m_s2 !== 32'(k - 1)) $display("FAIL len0_sum k=%0d got %0d exp %0d", k, m_s2, k - 1); else npass++;
        ntot++; if (acc_cnt !== 32'(k - 2)) $display("FAIL len0_cnt k=%0d got %0d exp %0d", k, acc_cnt, k - 2); else npass++;
      end
      step(); din = din + 1;
    end
    do_arm();
    do_sync();
    for (int k = 1; k <= 3; k++) begin
      ntot++; if (end_of_acc !== (k == 3)) $display("FAIL len3_eoa k=%0d got %b", k, end_of_acc); else npass++;
      step(); din = din + 1;
    end
  endtask

  task automatic test_reset_async();
    acc_len = 16'd1; ce = 1'b1;
    do_arm();
    do_sync();
    for (int k = 0; k < 4; k++) begin
      step(); din = din + 1;
    end
    #2;
    rst = 1'b1;
    #1;
    ntot++; if ({armed, running, end_of_acc, acc_vld, sync_err} !== 5'b00100) $display("FAIL arst_flags got %b exp 00100", {armed, running, end_of_acc, acc_vld, sync_err}); else npass++;
    ntot++; if (acc_cnt !== 32'd0) $display("FAIL arst_cnt got %0d exp 0", acc_cnt); else npass++;
    rst = 1'b0;
    step();
    do_arm();
    arm = 1'b1; sync_in = 1'b1;
    step();
    arm = 1'b0; sync_in = 1'b0;
    ntot++; if ({armed, running} !== 2'b10) $display("FAIL armsync got %b exp 10", {armed, running}); else npass++;
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    ntot++; if ({armed, running} !== 2'b01) $display("FAIL lone_sync got %b exp 01", {armed, running}); else npass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ce_gating();
    test_sync_err();
    test_rearm();
    test_len_edge();
    test_reset_async();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
